fir_credit_arbiter: RTL and testbench
=====================================

Name: fir_credit_arbiter

Overview:
Two-requester, credit-based arbiter that shares one fir_cascade input link between two upstream producers.
- Owns the link's sender-side credit counter.
- Grants at most one word per cycle using round-robin.
- Registers the winning word onto the link with a source tag, so a downstream demux can route the filtered samples.
- Sits directly in front of fir_cascade. It replaces the hand-written credit loop that producers used to carry.

Parameters:
DATA_WIDTH, 16, sample width (signed).
FIFO_ADDR, 4, log2 of receiver FIFO depth.
N_CREDITS, 2**FIFO_ADDR, receiver FIFO depth. Initial credit count is N_CREDITS-1.

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
i_req0_valid  in  1  requester 0 has a word
i_req0_data  in  DATA_WIDTH  requester 0 sample (signed)
o_req0_ready  out  1  requester 0 word accepted this cycle
i_req1_valid  in  1  requester 1 has a word
i_req1_data  in  DATA_WIDTH  requester 1 sample (signed)
o_req1_ready  out  1  requester 1 word accepted this cycle
o_top_data_valid  out  1  link data valid
o_top_data_data  out  DATA_WIDTH  link data
o_valid  out  1  link valid (same value as o_top_data_valid)
o_src_id  out  1  requester index of current link word
i_increment_count  in  1  credit return pulse from fir_cascade, one credit per cycle high
o_credits  out  FIFO_ADDR+1  current credit count (debug)
o_credit_err  out  1  sticky credit-overflow flag

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high; it takes priority over all other updates.
- Reset values:
  - credits = N_CREDITS-1
  - rr_ptr = 0
  - o_top_data_valid = 0, o_valid = 0, o_top_data_data = 0, o_src_id = 0
  - o_credit_err = 0
  - ready outputs low during the reset cycle
- Available credits: avail = credits + i_increment_count, computed combinationally. A credit returned in cycle t is usable in cycle t.
- Grant (combinational): can_send = (avail != 0). Grants are issued only when can_send.
  - Only one requester valid: grant it.
  - Both valid: grant rr_ptr.
  - o_reqK_ready = grantK. At most one grant per cycle.
- Handshake: a word transfers when i_reqK_valid & o_reqK_ready. Requesters must hold data stable while valid and not ready. A ready without a matching valid never occurs.
- Round-robin: on any grant to requester k, rr_ptr <= ~k. With no grant, rr_ptr holds.
- Output register (latency 1 cycle from accept to link):
  - On a send: o_top_data_data <= selected data, o_src_id <= k, o_top_data_valid <= 1, o_valid <= 1.
  - Otherwise: both valids <= 0; data and src_id hold their previous values.
- Credit update: credits <= credits + i_increment_count - send. Boundary cases:
  - Return and send in the same cycle: net zero, including at credits=0.
  - Overflow: return with no send while credits == N_CREDITS-1. Credits saturate at N_CREDITS-1 and o_credit_err <= 1. The flag is sticky until reset.
- Reset mid-burst: the in-flight link word is dropped (valid cleared). Credits are restored to N_CREDITS-1, and the receiver is reset alongside.
- Invariant: credits never exceed N_CREDITS-1 and never underflow.

Decomposition:
- Package fir_credit_pkg:
  - DATA_WIDTH, FIFO_ADDR, N_CREDITS localparams
  - typedef sample_t (logic signed [DATA_WIDTH-1:0])
  - typedef credit_t (logic [FIFO_ADDR:0])
- Sub-module credit_counter, shared with future single-producer senders:
  - inputs: clock, reset, inc, dec
  - outputs: count, avail_nz, err
- Arbitration and the output register stay in fir_credit_arbiter.

Test Plan:
1. Reset check: assert reset for 2 cycles, then release -> o_credits=15, link valids 0, o_credit_err=0, o_src_id=0.
2. Credit exhaustion: req0 valid continuously with data 0..19, i_increment_count=0 -> exactly 15 accepts. o_req0_ready drops on the 16th word and o_credits=0. Pulse i_increment_count for 1 cycle -> word 15 accepted that same cycle, and appears on the link one cycle later.
3. Fair sharing: both requesters valid continuously, i_increment_count=1 always -> grants alternate 0,1,0,1. o_src_id sequence matches with 1-cycle lag, credits stay at 15.
4. Simultaneous events: at credits=0, hold send with i_increment_count=1 for 10 cycles -> 10 words transferred, credits stay 0 throughout, no error.
5. Overflow: idle at credits=15, pulse i_increment_count -> credits stay 15, o_credit_err=1, and it stays 1 until reset.
6. Mid-burst reset: reset asserted with credits=7 and a word on the link -> next cycle valids 0, credits=15, rr_ptr=0.

Source files
------------

// File: rtl/fir_credit_pkg.sv
// Shared types and sizing for the fir_cascade credit-based sender side.
// Imported by the credit counter and the two-requester arbiter.
package fir_credit_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_ADDR  = 4;
    localparam int N_CREDITS  = 2 ** FIFO_ADDR;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic [FIFO_ADDR:0]           credit_t;

    // The receiver keeps one FIFO slot in reserve, so the sender starts one short of the depth.
    localparam credit_t CREDIT_MAX = credit_t'(N_CREDITS - 1);

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_t;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Sender-side credit counter: one credit returned per inc pulse, one spent per dec.
// Saturates at CREDIT_MAX and raises a sticky error on overflow.
module credit_counter
    import fir_credit_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    inc,
    input  logic    dec,
    output credit_t count,
    output logic    avail_nz,
    output logic    err
);

    credit_t count_q, count_d;
    logic    err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({inc, dec})
            2'b10: begin
                if (count_q == CREDIT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q + credit_t'(1);
                end
            end
            2'b01: begin
                // A spend is only ever issued with a nonzero count; the guard keeps the invariant local.
                if (count_q != '0) begin
                    count_d = count_q - credit_t'(1);
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CREDIT_MAX;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // A credit returned this cycle is immediately spendable.
    assign avail_nz = (count_q != '0) || inc;
    assign count    = count_q;
    assign err      = err_q;

endmodule

// File: rtl/fir_credit_arbiter.sv
// Two-requester round-robin arbiter feeding one fir_cascade input link.
// Owns the link credits and registers the winning word with its source tag.
module fir_credit_arbiter
    import fir_credit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req0_valid,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_top_data_valid,
    output logic [DATA_WIDTH-1:0] o_top_data_data,
    output logic                  o_valid,
    output logic                  o_src_id,
    input  logic                  i_increment_count,
    output logic [FIFO_ADDR:0]    o_credits,
    output logic                  o_credit_err
);

    src_t    rr_q, rr_d;
    logic    link_valid_q, link_valid_d;
    sample_t link_data_q, link_data_d;
    src_t    src_q, src_d;

    logic    can_send;
    logic    grant0;
    logic    grant1;
    logic    send;
    src_t    sel_src;
    sample_t sel_data;
    credit_t credit_count;
    logic    credit_err;

    credit_counter u_credit_counter (
        .clock    (clock),
        .reset    (reset),
        .inc      (i_increment_count),
        .dec      (send),
        .count    (credit_count),
        .avail_nz (can_send),
        .err      (credit_err)
    );

    // The pointer only breaks ties; a lone requester always wins when credit allows.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        sel_src  = SRC_REQ0;
        sel_data = sample_t'(i_req0_data);
        if (!reset && can_send) begin
            if (i_req0_valid && (!i_req1_valid || rr_q == SRC_REQ0)) begin
                grant0 = 1'b1;
            end else if (i_req1_valid) begin
                grant1   = 1'b1;
                sel_src  = SRC_REQ1;
                sel_data = sample_t'(i_req1_data);
            end
        end
        send = grant0 || grant1;
    end

    always_comb begin
        rr_d         = rr_q;
        link_valid_d = 1'b0;
        link_data_d  = link_data_q;
        src_d        = src_q;
        if (send) begin
            rr_d         = other_src(sel_src);
            link_valid_d = 1'b1;
            link_data_d  = sel_data;
            src_d        = sel_src;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q         <= SRC_REQ0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            src_q        <= SRC_REQ0;
        end else begin
            rr_q         <= rr_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            src_q        <= src_d;
        end
    end

    assign o_req0_ready     = grant0;
    assign o_req1_ready     = grant1;
    assign o_top_data_valid = link_valid_q;
    assign o_valid          = link_valid_q;
    assign o_top_data_data  = link_data_q;
    assign o_src_id         = src_q;
    assign o_credits        = credit_count;
    assign o_credit_err     = credit_err;

endmodule

// File: tb/tb_fir_credit_arbiter.sv
// Directed bench for fir_credit_arbiter: reset, credit exhaustion, fairness,
// simultaneous return/spend, overflow and mid-burst reset.
module tb_fir_credit_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req0_valid;
    logic [15:0] i_req0_data;
    logic        o_req0_ready;
    logic        i_req1_valid;
    logic [15:0] i_req1_data;
    logic        o_req1_ready;
    logic        o_top_data_valid;
    logic [15:0] o_top_data_data;
    logic        o_valid;
    logic        o_src_id;
    logic        i_increment_count;
    logic [4:0]  o_credits;
    logic        o_credit_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fir_credit_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .i_req0_valid      (i_req0_valid),
        .i_req0_data       (i_req0_data),
        .o_req0_ready      (o_req0_ready),
        .i_req1_valid      (i_req1_valid),
        .i_req1_data       (i_req1_data),
        .o_req1_ready      (o_req1_ready),
        .o_top_data_valid  (o_top_data_valid),
        .o_top_data_data   (o_top_data_data),
        .o_valid           (o_valid),
        .o_src_id          (o_src_id),
        .i_increment_count (i_increment_count),
        .o_credits         (o_credits),
        .o_credit_err      (o_credit_err)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_req0_valid = 1'b1;
        i_req0_data = 16'h0BAD;
        i_req1_valid = 1'b0;
        i_req1_data = 16'h0000;
        i_increment_count = 1'b0;
        step();
        #1;
        total++;
        if (o_req0_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready0 got=%b exp=0", o_req0_ready);
        end
        step();
        total++;
        if (o_credits !== 5'd15) begin
            bad++;
            $display("[TB] FAIL reset_credits got=%0d exp=15", o_credits);
        end
        total++;
        if (o_top_data_valid !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valids got=%b%b exp=00", o_top_data_valid, o_valid);
        end
        total++;
        if (o_credit_err !== 1'b0 || o_src_id !== 1'b0 || o_top_data_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_misc err=%b src=%b data=%h exp=0/0/0000",
                     o_credit_err, o_src_id, o_top_data_data);
        end
        reset = 1'b0;
        i_req0_valid = 1'b0;
    endtask

    task automatic test_credit_exhaust;
        int word = 0;
        int accepts = 0;
        logic accepted;
        for (int cyc = 0; cyc < 20; cyc++) begin
            i_req0_valid = 1'b1;
            i_req0_data = 16'(word);
            #1;
            accepted = o_req0_ready;
            if (accepted) accepts++;
            step();
            total++;
            if (accepted && (o_valid !== 1'b1 || o_top_data_data !== 16'(word) || o_src_id !== 1'b0)) begin
                bad++;
                $display("[TB] FAIL exhaust_link cyc=%0d got v=%b d=%0d s=%b exp v=1 d=%0d s=0",
                         cyc, o_valid, o_top_data_data, o_src_id, word);
            end else if (!accepted && o_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL exhaust_idle cyc=%0d got v=%b exp=0", cyc, o_valid);
            end
            if (accepted) word++;
        end
        total++;
        if (accepts != 15) begin
            bad++;
            $display("[TB] FAIL exhaust_accepts got=%0d exp=15", accepts);
        end
        #1;
        total++;
        if (o_credits !== 5'd0 || o_req0_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL exhaust_empty credits=%0d ready=%b exp 0/0", o_credits, o_req0_ready);
        end
        i_increment_count = 1'b1;
        #1;
        total++;
        if (o_req0_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL exhaust_return_ready got=%b exp=1", o_req0_ready);
        end
        step();
        i_increment_count = 1'b0;
        i_req0_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_top_data_data !== 16'd15 || o_credits !== 5'd0) begin
            bad++;
            $display("[TB] FAIL exhaust_word15 v=%b d=%0d credits=%0d exp 1/15/0",
                     o_valid, o_top_data_data, o_credits);
        end
    endtask

    task automatic test_simultaneous;
        i_increment_count = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_req1_valid = 1'b1;
            i_req1_data = 16'(100 + i);
            #1;
            total++;
            if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL simul_ready i=%0d got r0=%b r1=%b exp 0/1", i, o_req0_ready, o_req1_ready);
            end
            step();
            total++;
            if (o_credits !== 5'd0 || o_top_data_data !== 16'(100 + i) || o_src_id !== 1'b1 || o_credit_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL simul_state i=%0d credits=%0d d=%0d s=%b err=%b exp 0/%0d/1/0",
                         i, o_credits, o_top_data_data, o_src_id, o_credit_err, 100 + i);
            end
        end
        i_req1_valid = 1'b0;
    endtask

    task automatic test_fair_share;
        int n0 = 0;
        int n1 = 0;
        logic [15:0] exp_data;
        int exp_k;
        // refill from 0 to 15 with no traffic
        for (int i = 0; i < 15; i++) step();
        total++;
        if (o_credits !== 5'd15 || o_credit_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fair_refill credits=%0d err=%b exp 15/0", o_credits, o_credit_err);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            i_req0_valid = 1'b1;
            i_req1_valid = 1'b1;
            i_req0_data = 16'h1000 + 16'(n0);
            i_req1_data = 16'h2000 + 16'(n1);
            exp_k = cyc % 2;
            #1;
            total++;
            if (o_req0_ready !== (exp_k == 0) || o_req1_ready !== (exp_k == 1)) begin
                bad++;
                $display("[TB] FAIL fair_grant cyc=%0d got r0=%b r1=%b exp winner=%0d",
                         cyc, o_req0_ready, o_req1_ready, exp_k);
            end
            exp_data = (exp_k == 0) ? 16'h1000 + 16'(n0) : 16'h2000 + 16'(n1);
            if (exp_k == 0) n0++; else n1++;
            step();
            total++;
            if (o_src_id !== exp_k[0] || o_top_data_data !== exp_data || o_credits !== 5'd15 || o_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL fair_link cyc=%0d s=%b d=%h credits=%0d v=%b exp s=%0d d=%h 15 1",
                         cyc, o_src_id, o_top_data_data, o_credits, o_valid, exp_k, exp_data);
            end
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_increment_count = 1'b0;
        step();
        total++;
        if (o_credit_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fair_err got=%b exp=0", o_credit_err);
        end
    endtask

    task automatic test_overflow;
        i_increment_count = 1'b1;
        step();
        i_increment_count = 1'b0;
        total++;
        if (o_credits !== 5'd15 || o_credit_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_set credits=%0d err=%b exp 15/1", o_credits, o_credit_err);
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if (o_credit_err !== 1'b1 || o_credits !== 5'd15) begin
            bad++;
            $display("[TB] FAIL overflow_sticky err=%b credits=%0d exp 1/15", o_credit_err, o_credits);
        end
    endtask

    task automatic test_midburst_reset;
        for (int i = 0; i < 8; i++) begin
            i_req0_valid = 1'b1;
            i_req0_data = 16'h0A00 + 16'(i);
            step();
        end
        total++;
        if (o_credits !== 5'd7 || o_valid !== 1'b1 || o_top_data_data !== 16'h0A07) begin
            bad++;
            $display("[TB] FAIL burst_pre credits=%0d v=%b d=%h exp 7/1/0a07", o_credits, o_valid, o_top_data_data);
        end
        reset = 1'b1;
        #1;
        total++;
        if (o_req0_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_reset_ready got=%b exp=0", o_req0_ready);
        end
        step();
        total++;
        if (o_valid !== 1'b0 || o_top_data_valid !== 1'b0 || o_credits !== 5'd15 || o_credit_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_reset_state v=%b%b credits=%0d err=%b exp 00/15/0",
                     o_valid, o_top_data_valid, o_credits, o_credit_err);
        end
        reset = 1'b0;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        #1;
        total++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_rr_ptr got r0=%b r1=%b exp 1/0", o_req0_ready, o_req1_ready);
        end
        step();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_credit_exhaust();
        test_simultaneous();
        test_fair_share();
        test_overflow();
        test_midburst_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
